// File: rtl/params_share_pkg.sv
// Shared parameters for the beta accumulate/average path: beta_acc_nch sizes, cfg field
// offsets and the FSM state type.
package params_share_pkg;

   localparam int unsigned BETA_ACC_NUM_CH = 4;
   localparam int unsigned BETA_ACC_DATA_W = 16;
   localparam int unsigned BETA_ACC_EXP_W  = 5;
   localparam int unsigned BETA_ACC_ACC_W  = 32;

   localparam int unsigned BETA_ACC_CFG_SHIFT_LSB = 0;
   localparam int unsigned BETA_ACC_CFG_SHIFT_W   = 5;
   localparam int unsigned BETA_ACC_CFG_MASK_LSB  = 8;

   typedef enum logic [2:0] {IDLE, ACC, AVG, NORM, OUT} beta_acc_state_t;

endpackage

// File: rtl/beta_lead_norm.sv
// Shared-exponent normaliser: picks the smallest right shift that makes every enabled value
// fit DATA_W signed, and produces the shifted (saturated on clamp) mantissas.
module beta_lead_norm
   import params_share_pkg::*;
#(
   parameter int unsigned NUM_CH = BETA_ACC_NUM_CH,
   parameter int unsigned DATA_W = BETA_ACC_DATA_W,
   parameter int unsigned EXP_W  = BETA_ACC_EXP_W,
   parameter int unsigned ACC_W  = BETA_ACC_ACC_W
) (
   input  logic [NUM_CH*ACC_W-1:0]  val,
   input  logic [NUM_CH-1:0]        mask,
   output logic [NUM_CH*DATA_W-1:0] mant,
   output logic [EXP_W-1:0]         norm_exp,
   output logic                     clamp
);

   localparam int unsigned MaxShift = ACC_W - DATA_W;

   // Fits iff every bit from DATA_W-1 upward of (v >>> s) equals the sign.
   function automatic logic fits(input logic [ACC_W-1:0] v, input int unsigned s);
      logic [ACC_W-1:0] top;
      top = $signed(v) >>> (s + DATA_W - 1);
      return (&top) | ~(|top);
   endfunction

   logic all_fit;

   always_comb begin
      norm_exp = EXP_W'(MaxShift);
      clamp    = 1'b1;
      all_fit  = 1'b0;
      for (int s = MaxShift; s >= 0; s--) begin
         all_fit = 1'b1;
         for (int k = 0; k < NUM_CH; k++) begin
            if (mask[k] && !fits(val[k*ACC_W +: ACC_W], s)) all_fit = 1'b0;
         end
         if (all_fit) begin
            norm_exp = EXP_W'(s);
            clamp    = 1'b0;
         end
      end
   end

   always_comb begin
      mant = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (!mask[k]) begin
            mant[k*DATA_W +: DATA_W] = '0;
         end else if (fits(val[k*ACC_W +: ACC_W], 32'(norm_exp))) begin
            mant[k*DATA_W +: DATA_W] = DATA_W'($signed(val[k*ACC_W +: ACC_W]) >>> norm_exp);
         end else if (val[k*ACC_W + ACC_W - 1]) begin
            mant[k*DATA_W +: DATA_W] = {1'b1, {(DATA_W-1){1'b0}}};
         end else begin
            mant[k*DATA_W +: DATA_W] = {1'b0, {(DATA_W-1){1'b1}}};
         end
      end
   end

endmodule

// File: rtl/beta_acc_nch.sv
// Multi-channel beta accumulator/averager with block-floating-point output.
// Define BETA_ACC_ROUND_EN for round-half-up averaging; default truncates.
module beta_acc_nch
   import params_share_pkg::*;
#(
   parameter int unsigned NUM_CH = BETA_ACC_NUM_CH,
   parameter int unsigned DATA_W = BETA_ACC_DATA_W,
   parameter int unsigned EXP_W  = BETA_ACC_EXP_W,
   parameter int unsigned ACC_W  = BETA_ACC_ACC_W
) (
   input  logic                     clk,
   input  logic                     arst_n,
   input  logic [8+NUM_CH-1:0]      cfg_tdata,
   input  logic                     cfg_tvalid,
   output logic                     cfg_tready,
   input  logic [NUM_CH*DATA_W-1:0] in_tdata,
   input  logic [EXP_W-1:0]         in_texp,
   input  logic                     in_tvalid,
   input  logic                     in_tlast,
   output logic                     in_tready,
   output logic [NUM_CH*DATA_W-1:0] out_tdata,
   output logic [EXP_W-1:0]         out_texp,
   output logic                     out_sat,
   output logic                     out_tvalid,
   input  logic                     out_tready
);

   localparam int unsigned MaxExp = ACC_W - DATA_W;
   localparam int unsigned ShW    = $clog2(ACC_W);

   beta_acc_state_t state_q, state_d;
   logic                     run_q;
   logic [ShW-1:0]           avg_shift_q, avg_shift_d;
   logic [NUM_CH-1:0]        mask_q, mask_d;
   logic [ACC_W-1:0]         acc_q [NUM_CH];
   logic [ACC_W-1:0]         acc_d [NUM_CH];
   logic                     sat_q, sat_d;
   logic [NUM_CH*DATA_W-1:0] out_data_q;
   logic [EXP_W-1:0]         out_exp_q;
   logic                     out_sat_q;

   logic                      cfg_hs, in_hs, out_hs;
   logic [BETA_ACC_CFG_SHIFT_W-1:0] cfg_shift;
   logic [EXP_W-1:0]          exp_eff;
   logic                      exp_clamp;
   logic [ACC_W-1:0]          ext, val;
   logic [ACC_W:0]            sum;
   logic [NUM_CH*ACC_W-1:0]   acc_flat;
   logic [NUM_CH*DATA_W-1:0]  norm_mant;
   logic [EXP_W-1:0]          norm_exp;
   logic                      norm_clamp;
   logic                      unused_cfg_rsvd;

   // Returns {overflow, saturated sum}.
   function automatic logic [ACC_W:0] add_sat(input logic [ACC_W-1:0] a,
                                              input logic [ACC_W-1:0] b);
      logic [ACC_W:0] s;
      s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
      if (s[ACC_W] != s[ACC_W-1]) return {1'b1, s[ACC_W], {(ACC_W-1){~s[ACC_W]}}};
      return {1'b0, s[ACC_W-1:0]};
   endfunction

   assign cfg_shift       = cfg_tdata[BETA_ACC_CFG_SHIFT_LSB +: BETA_ACC_CFG_SHIFT_W];
   assign unused_cfg_rsvd = ^cfg_tdata[BETA_ACC_CFG_MASK_LSB-1:BETA_ACC_CFG_SHIFT_W];
   assign cfg_hs = cfg_tvalid & cfg_tready;
   assign in_hs  = in_tvalid & in_tready;
   assign out_hs = out_tvalid & out_tready;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (cfg_hs) state_d = ACC;
         ACC:     if (in_hs && in_tlast) state_d = AVG;
         AVG:     state_d = NORM;
         NORM:    state_d = OUT;
         OUT:     if (out_hs) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // run_q keeps cfg_tready low while reset is asserted.
   always_comb begin
      cfg_tready = (state_q == IDLE) && run_q;
      in_tready  = (state_q == ACC);
      out_tvalid = (state_q == OUT);
   end

   always_comb begin
      avg_shift_d = avg_shift_q;
      mask_d      = mask_q;
      sat_d       = sat_q;
      ext         = '0;
      val         = '0;
      sum         = '0;
      exp_eff     = in_texp;
      exp_clamp   = 1'b0;
      for (int k = 0; k < NUM_CH; k++) acc_d[k] = acc_q[k];
      if (32'(in_texp) > MaxExp) begin
         exp_eff   = EXP_W'(MaxExp);
         exp_clamp = 1'b1;
      end
      unique case (state_q)
         IDLE: if (cfg_hs) begin
            avg_shift_d = (32'(cfg_shift) > ACC_W - 1) ? ShW'(ACC_W - 1) : ShW'(cfg_shift);
            mask_d      = cfg_tdata[BETA_ACC_CFG_MASK_LSB +: NUM_CH];
            sat_d       = 1'b0;
            for (int k = 0; k < NUM_CH; k++) acc_d[k] = '0;
         end
         ACC: if (in_hs) begin
            if (exp_clamp) sat_d = 1'b1;
            for (int k = 0; k < NUM_CH; k++) begin
               if (mask_q[k]) begin
                  ext = {{(ACC_W-DATA_W){in_tdata[k*DATA_W + DATA_W - 1]}},
                         in_tdata[k*DATA_W +: DATA_W]};
                  sum = add_sat(acc_q[k], ext << exp_eff);
                  acc_d[k] = sum[ACC_W-1:0];
                  if (sum[ACC_W]) sat_d = 1'b1;
               end
            end
         end
         AVG: begin
            for (int k = 0; k < NUM_CH; k++) begin
               val = acc_q[k];
`ifdef BETA_ACC_ROUND_EN
               if (avg_shift_q != '0) begin
                  sum = add_sat(val, ACC_W'(1) << (avg_shift_q - 1'b1));
                  val = sum[ACC_W-1:0];
                  if (sum[ACC_W]) sat_d = 1'b1;
               end
`endif
               acc_d[k] = $signed(val) >>> avg_shift_q;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      acc_flat = '0;
      for (int k = 0; k < NUM_CH; k++) acc_flat[k*ACC_W +: ACC_W] = acc_q[k];
   end

   beta_lead_norm #(
      .NUM_CH (NUM_CH),
      .DATA_W (DATA_W),
      .EXP_W  (EXP_W),
      .ACC_W  (ACC_W)
   ) u_lead_norm (
      .val      (acc_flat),
      .mask     (mask_q),
      .mant     (norm_mant),
      .norm_exp (norm_exp),
      .clamp    (norm_clamp)
   );

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         run_q       <= 1'b0;
         avg_shift_q <= '0;
         mask_q      <= '0;
         sat_q       <= 1'b0;
         out_data_q  <= '0;
         out_exp_q   <= '0;
         out_sat_q   <= 1'b0;
         for (int k = 0; k < NUM_CH; k++) acc_q[k] <= '0;
      end else begin
         run_q       <= 1'b1;
         avg_shift_q <= avg_shift_d;
         mask_q      <= mask_d;
         sat_q       <= sat_d;
         for (int k = 0; k < NUM_CH; k++) acc_q[k] <= acc_d[k];
         if (state_q == NORM) begin
            out_data_q <= norm_mant;
            out_exp_q  <= norm_exp;
            out_sat_q  <= sat_q | norm_clamp;
         end
      end
   end

   assign out_tdata = out_data_q;
   assign out_texp  = out_exp_q;
   assign out_sat   = out_sat_q;

endmodule

// File: doc/beta_acc_nch.md
# beta_acc_nch

Multi-channel beta accumulator/averager with block-floating-point output, the parametrised successor of the single-channel beta RHH accumulate/average path inside the combiner. It accepts NUM_CH signed mantissas sharing one exponent per AXI-stream beat. It accumulates each channel over a tlast-delimited window, averages by a configured right shift, and renormalises to a DATA_W mantissa plus a shared exponent. It sits between the combiner channel-estimate stage and the PSINR calculation.

## Interface
- NUM_CH, 4, number of channels per beat
- DATA_W, 16, signed mantissa width per channel
- EXP_W, 5, shared exponent width; value = mantissa * 2^exp
- ACC_W, 32, signed accumulator width per channel
- clk  in  1  clock
- arst_n  in  1  reset; one clock, asynchronous, active-low
- cfg_tdata  in  8+NUM_CH  [4:0] avg_shift, [7:5] reserved, [8+:NUM_CH] ch_mask (1 = enabled)
- cfg_tvalid / cfg_tready  in / out  1  config handshake
- in_tdata  in  NUM_CH*DATA_W  channel k at [k*DATA_W+:DATA_W]
- in_texp  in  EXP_W  shared input exponent
- in_tvalid / in_tlast / in_tready  in / in / out  1  input stream; tlast = last beat of window
- out_tdata  out  NUM_CH*DATA_W  normalised averaged mantissas
- out_texp  out  EXP_W  shared output exponent (normalisation shift)
- out_sat  out  1  sticky: saturation or exponent clamp occurred in this window
- out_tvalid / out_tready  out / in  1  output handshake, one beat per window

## Operation
- FSM states IDLE, ACC, AVG, NORM, OUT. Reset state IDLE.
- IDLE: cfg_tready=1. Config handshake latches avg_shift (clamped to ACC_W-1) and ch_mask, clears accumulators and sat, then moves to ACC.
- ACC: in_tready=1. Each accepted beat sign-extends every enabled mantissa to ACC_W, shifts left by in_texp, and adds it with saturation to ±(2^(ACC_W-1)-1 / -2^(ACC_W-1)).
  - in_texp > ACC_W-DATA_W is clamped to ACC_W-DATA_W and sets sat.
  - Saturation also sets sat.
  - Masked channels stay 0.
  - A beat with tlast moves to AVG.
- AVG: each accumulator is arithmetically shifted right by avg_shift (rounding per Configuration). Then moves to NORM.
- NORM: finds the minimum s in 0..ACC_W-DATA_W such that every enabled averaged value fits DATA_W signed. out mantissa = value >>> s (truncated), out_texp = s. Then moves to OUT.
  - If s would exceed ACC_W-DATA_W, s is clamped to ACC_W-DATA_W and each mantissa saturates.
- OUT: out_tvalid=1 and outputs are stable until out_tready. On handshake, moves to IDLE.
- cfg_tready=0 and in_tready=0 in every state other than their own, so cfg and input beats never collide.

## Timing
- Reset values: all outputs 0 (cfg_tready and in_tready 0 during reset). cfg_tready rises in the first cycle after deassertion.
- Reset mid-window drops all state; no output is produced.
- Latency: tlast beat accepted at cycle T gives out_tvalid=1 at T+3.
- out_tvalid is deasserted the cycle after the output handshake. cfg_tready=1 in that same cycle.
- Minimum window throughput: 1 cfg cycle + N beats + 3 + stall cycles.
- out_tready held low: outputs stay stable and no input or cfg is accepted.
- Input gaps (in_tvalid=0) in ACC: accumulators hold.
- Single-beat window (tlast on the first beat) is legal.

## Configuration
- BETA_ACC_ROUND_EN defined: in AVG, add 2^(avg_shift-1) (when avg_shift>0, with saturation) before the shift, giving round-half-up.
- BETA_ACC_ROUND_EN undefined: plain truncating arithmetic shift.

## Structure
- params_share_pkg gains:
  - BETA_ACC_NUM_CH, BETA_ACC_DATA_W, BETA_ACC_EXP_W, BETA_ACC_ACC_W
  - the cfg field offsets
  - typedef enum beta_acc_state_t {IDLE, ACC, AVG, NORM, OUT}
- One sub-module, beta_lead_norm: combinational shared-exponent leading-bit detect and shift over NUM_CH values, registered by the parent in NORM.

## Test plan
- **Basic average:** cfg avg_shift=2, ch_mask=4'hF; 4 beats with all mantissas 100, texp=0, tlast on beat 4.
  - Expect out mantissas 100 and texp 0, out_sat=0, out_tvalid 3 cycles after the tlast beat.
- **Normalisation:** avg_shift=0; 1 beat with ch0=16384, texp=3, others 0.
  - Expect out ch0=16384, out_texp=3.
- **Saturation:** 2 beats with ch0=32767, texp=16.
  - Expect ch0 accumulator saturated at 2^31-1 and out_sat=1.
  - Expect out_texp=16, out ch0=32767.
- **Rounding:** avg_shift=1; ch0=3, ch1=-3.
  - With BETA_ACC_ROUND_EN: expect 2, -1.
  - Without it: expect 1, -2.
- **Backpressure:** out_tready=0 for 5 cycles.
  - Expect out_tdata/out_texp stable, in_tready=0, cfg_tready=0.
  - Release: expect handshake, then cfg_tready=1 the next cycle.
- **Mask and reset:** ch_mask=4'b0101 with all inputs 500.
  - Expect out ch1 and ch3 = 0.
  - Assert arst_n low after 2 beats of the next window: expect no output and cfg_tready=1 after release.
